// File: rtl/mem_wb_stage_if.sv
// Data-memory request/response bus between the RV32I memory stage and data memory.
interface mem_wb_stage_if #(
  parameter int W = 32
);
  logic         dmem_req;
  logic         dmem_we;
  logic [W-1:0] dmem_addr;
  logic [3:0]   dmem_be;
  logic [W-1:0] dmem_wdata;
  logic         dmem_ack;
  logic [W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_wb_stage.sv
// RV32I memory stage + MEM/WB register: lane steering, load extension, req/ack stall.
// Optional macro DMEM_TIMEOUT_EN aborts a WAIT after TIMEOUT cycles and flags BusErrW.
module mem_wb_stage #(
  parameter int W       = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ValidM,
  input  logic [1:0]    ResultSrcM,
  input  logic          RegWriteM,
  input  logic          MemWriteM,
  input  logic [2:0]    Funct3M,
  input  logic [W-1:0]  ALUResultM,
  input  logic [W-1:0]  WriteDataM,
  input  logic [AW-1:0] RdM,
  input  logic [W-1:0]  PCPlus4M,
  mem_wb_stage_if.master dmem,
  output logic          StallM,
  output logic          ValidW,
  output logic          RegWriteW,
  output logic [1:0]    ResultSrcW,
  output logic [W-1:0]  ALUResultW,
  output logic [W-1:0]  ReadDataW,
  output logic [W-1:0]  PCPlus4W,
  output logic [AW-1:0] RdW,
  output logic          MisalignW,
  output logic          BusErrW
);

  if (W != 32) begin : g_bad_width
    $error("mem_wb_stage supports W=32 only");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("mem_wb_stage TIMEOUT must be >= 2");
  end

  typedef enum logic {IDLE, WAIT} state_t;

  function automatic logic [3:0] st_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [W-1:0] st_wdata(input logic [2:0] f3, input logic [W-1:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [W-1:0] ld_extract(input logic [W-1:0] rdata,
                                              input logic [2:0]   f3,
                                              input logic [1:0]   off);
    logic signed [7:0]   b;
    logic signed [15:0]  h;
    logic signed [W-1:0] sx;
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  begin sx = b; return sx; end
      3'b001:  begin sx = h; return sx; end
      3'b100:  return {{(W-8){1'b0}}, b};
      3'b101:  return {{(W-16){1'b0}}, h};
      default: return rdata;
    endcase
  endfunction

  state_t     state, state_nxt;
  logic [1:0] off_p0;
  logic       mem_op_p0, load_p0, misalign_p0, aligned_p0, abort_p0;
  logic [W-1:0] ld_data_p0;

  assign off_p0      = ALUResultM[1:0];
  assign mem_op_p0   = ValidM & (MemWriteM | (ResultSrcM == 2'b01));
  assign load_p0     = mem_op_p0 & ~MemWriteM;
  assign misalign_p0 = mem_op_p0 & (((Funct3M[1:0] == 2'b01) & off_p0[0]) |
                                    ((Funct3M[1:0] == 2'b10) & (off_p0 != 2'b00)));
  assign aligned_p0  = mem_op_p0 & ~misalign_p0;
  assign ld_data_p0  = ld_extract(dmem.dmem_rdata, Funct3M, off_p0);

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] cnt;

  assign abort_p0 = (state == WAIT) & aligned_p0 & ~dmem.dmem_ack &
                    (cnt == CW'(TIMEOUT - 1));

  // Counter restarts whenever WAIT is entered from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (state == IDLE)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end
`else
  assign abort_p0 = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (aligned_p0 & ~dmem.dmem_ack) state_nxt = WAIT;
      WAIT: if (dmem.dmem_ack | ~aligned_p0 | abort_p0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request is gated by rst_n so it drops the instant reset asserts.
  assign StallM          = rst_n & aligned_p0 & ~dmem.dmem_ack & ~abort_p0;
  assign dmem.dmem_req   = rst_n & aligned_p0 & ~abort_p0;
  assign dmem.dmem_we    = dmem.dmem_req & MemWriteM;
  assign dmem.dmem_addr  = {ALUResultM[W-1:2], 2'b00};
  assign dmem.dmem_be    = MemWriteM ? st_be(Funct3M, off_p0) : 4'b1111;
  assign dmem.dmem_wdata = st_wdata(Funct3M, WriteDataM);

  // ---- MEM/WB boundary ----
  logic buserr_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ValidW     <= 1'b0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
      MisalignW  <= 1'b0;
      buserr_p1  <= 1'b0;
    end else if (StallM) begin
      ValidW    <= 1'b0;
      RegWriteW <= 1'b0;
      MisalignW <= 1'b0;
      buserr_p1 <= 1'b0;
    end else begin
      ValidW     <= ValidM;
      RegWriteW  <= RegWriteM & ValidM & ~MemWriteM & ~misalign_p0 & ~abort_p0;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= (load_p0 & ~misalign_p0 & ~abort_p0) ? ld_data_p0 : '0;
      PCPlus4W   <= PCPlus4M;
      RdW        <= RdM;
      MisalignW  <= misalign_p0;
      buserr_p1  <= abort_p0;
    end
  end

`ifdef DMEM_TIMEOUT_EN
  assign BusErrW = buserr_p1;
`else
  assign BusErrW = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized self-checking bench for mem_wb_stage against a size/offset arithmetic model.
module tb_mem_wb_stage;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ValidM, RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        StallM, ValidW, RegWriteW, MisalignW, BusErrW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;

  int checks = 0;
  int failures = 0;

  mem_wb_stage_if #(.W(32)) dmem ();

  mem_wb_stage #(.W(32), .AW(5), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ValidM(ValidM), .ResultSrcM(ResultSrcM),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .dmem(dmem.master), .StallM(StallM), .ValidW(ValidW), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
    .PCPlus4W(PCPlus4W), .RdW(RdW), .MisalignW(MisalignW), .BusErrW(BusErrW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic m_mis(input logic [2:0] f3, input logic [1:0] off);
    return (nbytes(f3) == 2 && off[0]) || (nbytes(f3) == 4 && off != 2'b00);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off);
    int v;
    v = ((1 << nbytes(f3)) - 1) << off;
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (nbytes(f3))
      1:       return {24'b0, wd[7:0]} * 32'h0101_0101;
      2:       return {16'b0, wd[15:0]} * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [2:0] f3,
                                         input logic [1:0] off);
    longint v, bits;
    if (nbytes(f3) == 4) return rdata;
    bits = 8 * nbytes(f3);
    v = longint'(rdata) >> (8 * off);
    v = v & ((longint'(1) << bits) - 1);
    if (!f3[2] && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return v[31:0];
  endfunction

  // Called just after a rising edge; leaves time just after the capturing edge.
  task automatic do_op(input logic v, input logic [1:0] rs, input logic rw, input logic mw,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [31:0] pc4, input int d,
                       input logic [31:0] rdata);
    logic memop, mis, req_e, ld;
    ValidM = v; ResultSrcM = rs; RegWriteM = rw; MemWriteM = mw; Funct3M = f3;
    ALUResultM = alu; WriteDataM = wd; RdM = rd; PCPlus4M = pc4;
    memop = v && (mw || rs == 2'b01);
    mis   = memop && m_mis(f3, alu[1:0]);
    req_e = memop && !mis;
    ld    = req_e && !mw;
    dmem.dmem_rdata = rdata;
    dmem.dmem_ack   = req_e && d == 0;
    for (int c = 0; c <= (req_e ? d : 0); c++) begin
      @(negedge clk);
      chk("req", dmem.dmem_req, req_e);
      if (req_e) begin
        chk("addr", dmem.dmem_addr, {alu[31:2], 2'b00});
        chk("we", dmem.dmem_we, mw);
        chk("be", dmem.dmem_be, mw ? m_be(f3, alu[1:0]) : 4'hF);
        if (mw) chk("wdata", dmem.dmem_wdata, m_wdata(f3, wd));
      end
      chk("stall", StallM, req_e && c < d);
      @(posedge clk); #1;
      if (req_e && c < d) begin
        chk("bubble_valid", ValidW, 1'b0);
        chk("bubble_regwr", RegWriteW, 1'b0);
        dmem.dmem_ack = (c + 1 == d);
      end
    end
    dmem.dmem_ack = 1'b0;
    chk("ValidW", ValidW, v);
    chk("RegWriteW", RegWriteW, rw && v && !mw && !mis);
    chk("ResultSrcW", ResultSrcW, rs);
    chk("ALUResultW", ALUResultW, alu);
    chk("PCPlus4W", PCPlus4W, pc4);
    chk("RdW", RdW, rd);
    chk("ReadDataW", ReadDataW, ld ? m_load(rdata, f3, alu[1:0]) : 32'h0);
    chk("MisalignW", MisalignW, mis);
    chk("BusErrW", BusErrW, 1'b0);
  endtask

  initial begin
    int ty, d, n;
    logic [2:0] f3;
    logic [2:0] ldf3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    rst_n = 1'b0;
    ValidM = 0; ResultSrcM = 0; RegWriteM = 0; MemWriteM = 0; Funct3M = 0;
    ALUResultM = 0; WriteDataM = 0; RdM = 0; PCPlus4M = 0;
    dmem.dmem_ack = 0; dmem.dmem_rdata = 0;
    #2;
    chk("rst_req", dmem.dmem_req, 1'b0);
    chk("rst_valid", ValidW, 1'b0);
    chk("rst_alu", ALUResultW, 32'h0);
    chk("rst_misalign", MisalignW, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_op(1, 2'b00, 1, 0, 3'b010, 32'h1234, 32'h0, 5'd5, 32'h104, 0, 32'h0);
    do_op(1, 2'b01, 1, 0, 3'b000, 32'h103, 32'h0, 5'd6, 32'h108, 0, 32'h80FF_0000);
    chk("lb_value", ReadDataW, 32'hFFFF_FF80);
    do_op(1, 2'b01, 1, 0, 3'b101, 32'h102, 32'h0, 5'd7, 32'h10C, 3, 32'hBEEF_1234);
    chk("lhu_value", ReadDataW, 32'h0000_BEEF);
    do_op(1, 2'b00, 0, 1, 3'b000, 32'h201, 32'hAB, 5'd0, 32'h110, 1, 32'h0);
    do_op(1, 2'b00, 1, 1, 3'b001, 32'h202, 32'hCAFE, 5'd9, 32'h114, 0, 32'h0);
    do_op(1, 2'b01, 1, 0, 3'b010, 32'h302, 32'h0, 5'd3, 32'h118, 0, 32'h0);
    do_op(1, 2'b10, 1, 0, 3'b010, 32'h55, 32'h0, 5'd1, 32'h11C, 0, 32'h0);
`ifndef DMEM_TIMEOUT_EN
    do_op(1, 2'b01, 1, 0, 3'b010, 32'h400, 32'h0, 5'd2, 32'h120, 20, 32'h1357_9BDF);
`endif

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      ty = $urandom_range(0, 3);
      d  = $urandom_range(0, 4);
      case (ty)
        0: do_op(1, $urandom_range(0, 1) ? 2'b10 : 2'b00, 1'($urandom), 0, 3'($urandom),
                 $urandom, $urandom, 5'($urandom), $urandom, d, $urandom);
        1: begin
          f3 = ldf3[$urandom_range(0, 4)];
          do_op(1, 2'b01, 1'($urandom), 0, f3, $urandom, $urandom, 5'($urandom),
                $urandom, d, $urandom);
        end
        2: do_op(1, 2'b00, 1'($urandom), 1, 3'($urandom_range(0, 2)), $urandom, $urandom,
                 5'($urandom), $urandom, d, $urandom);
        default: do_op(0, 2'b01, 1'($urandom), 1'($urandom), 3'b010, $urandom, $urandom,
                       5'($urandom), $urandom, d, $urandom);
      endcase
    end

    // Asynchronous reset in the middle of an outstanding load
    do_op(1, 2'b00, 1, 0, 3'b010, 32'hA5A5_0000, 32'h0, 5'd11, 32'h200, 0, 32'h0);
    ValidM = 1; ResultSrcM = 2'b01; MemWriteM = 0; Funct3M = 3'b010; ALUResultM = 32'h500;
    dmem.dmem_ack = 0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    chk("wait_stall", StallM, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_req", dmem.dmem_req, 1'b0);
    chk("arst_alu", ALUResultW, 32'h0);
    chk("arst_rd", RdW, 5'd0);
    chk("arst_pc4", PCPlus4W, 32'h0);
    ValidM = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem.dmem_ack = 1'b1;
    @(negedge clk);
    chk("late_ack_req", dmem.dmem_req, 1'b0);
    chk("late_ack_stall", StallM, 1'b0);
    @(posedge clk); #1;
    dmem.dmem_ack = 1'b0;
    chk("late_ack_valid", ValidW, 1'b0);
    do_op(1, 2'b01, 1, 0, 3'b001, 32'h602, 32'h0, 5'd4, 32'h300, 2, 32'h8001_7FFF);

`ifdef DMEM_TIMEOUT_EN
    ValidM = 1; ResultSrcM = 2'b01; RegWriteM = 1; MemWriteM = 0; Funct3M = 3'b010;
    ALUResultM = 32'h700; RdM = 5'd8;
    n = 0;
    for (int c = 0; c < 3 * TIMEOUT; c++) begin
      @(negedge clk);
      if (!StallM) break;
      n++;
      @(posedge clk); #1;
    end
    chk("to_stall_cycles", n, TIMEOUT);
    chk("to_req_drop", dmem.dmem_req, 1'b0);
    @(posedge clk); #1;
    ValidM = 0;
    chk("to_buserr", BusErrW, 1'b1);
    chk("to_valid", ValidW, 1'b1);
    chk("to_regwr", RegWriteW, 1'b0);
    @(posedge clk); #1;
    chk("to_buserr_clear", BusErrW, 1'b0);
`else
    n = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory stage plus MEM/WB pipeline register of the 5-stage RV32I core; sits directly upstream of the writeback result mux.
- Issues loads/stores to data memory over a req/ack handshake and performs byte-lane steering, byte enables and load sign/zero extension.
- Stalls the upstream pipeline while memory is outstanding, then registers ALUResultW, ReadDataW, PCPlus4W, ResultSrcW, RegWriteW and RdW for writeback.

Parameters:
- W, 32, datapath width; only 32 is supported.
- AW, 5, register address width.
- TIMEOUT, 16, cycles allowed in WAIT before abort; used only with DMEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ValidM  in  1  M-stage instruction valid.
- ResultSrcM  in  2  result select: 00 ALU, 01 load, 10 PC+4.
- RegWriteM  in  1  register write enable.
- MemWriteM  in  1  store.
- Funct3M  in  3  access size/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use the low 2 bits).
- ALUResultM  in  W  address or ALU result.
- WriteDataM  in  W  store data (rs2).
- RdM  in  AW  destination register.
- PCPlus4M  in  W  PC+4.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write strobe.
- dmem_addr  out  W  word address, low 2 bits = 0.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  W  lane-steered store data.
- dmem_ack  in  1  request accepted/completed; read data valid this cycle.
- dmem_rdata  in  W  raw read word.
- StallM  out  1  hold all upstream stages.
- ValidW, RegWriteW  out  1 each.
- ResultSrcW  out  2.
- ALUResultW, ReadDataW, PCPlus4W  out  W each.
- RdW  out  AW.
- MisalignW  out  1  misaligned access flag.
- BusErrW  out  1  memory timeout flag.

Behaviour:
- mem_op = ValidM & (MemWriteM | ResultSrcM==01).
- Misaligned access:
  - Condition: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - No dmem_req is issued and there is no stall.
  - Next cycle: ValidW=1, RegWriteW=0, MisalignW=1.
- FSM states IDLE, WAIT; reset state IDLE.
  - IDLE: an aligned mem_op asserts dmem_req combinationally in the same cycle. If dmem_ack=1 that cycle, the access completes with zero stall. Otherwise StallM=1 and the FSM goes to WAIT.
  - WAIT: dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are held stable (driven from held M inputs, which are frozen by StallM). StallM = ~dmem_ack. On ack the FSM returns to IDLE.
  - StallM = aligned mem_op & ~dmem_ack, in either state.
- Byte enables / store steering, by addr[1:0]:
  - SB: be = 0001 << off; wdata = byte replicated ×4.
  - SH: be = 0011 << off; wdata = halfword replicated ×2.
  - SW: be = 1111.
  - Loads use be = 1111 and dmem_we = 0.
- Load extraction is from dmem_rdata on the ack cycle:
  - Select the byte/halfword by offset.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - The result is registered into ReadDataW.
- W register update, each edge:
  - If StallM=1: load a bubble (ValidW=0, RegWriteW=0, other fields don't-care, held).
  - Else: capture the M fields. ValidW=ValidM; RegWriteW=RegWriteM & ValidM & ~misalign; ReadDataW=extracted load data, or 0 for non-loads.
- Non-memory ops pass through with 1-cycle latency and no memory request.
- Reset (async, any state, including mid-WAIT):
  - FSM=IDLE; dmem_req=0 immediately.
  - All W outputs = 0; MisalignW = BusErrW = 0.
  - A late dmem_ack arriving in IDLE with no request is ignored.
- A store with RegWriteM=1 is illegal upstream; RegWriteW is forced to 0 when MemWriteM=1.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT-1 with no ack, the access aborts: dmem_req drops, FSM → IDLE, StallM=0.
  - Next cycle: ValidW=1, RegWriteW=0, BusErrW=1.
- Undefined: no counter; WAIT lasts indefinitely; BusErrW is tied to 0.

Test Plan:
- ALU op: ResultSrcM=00, ALUResultM=0x1234, RdM=5, RegWriteM=1 → next cycle ALUResultW=0x1234, RdW=5, RegWriteW=1; no dmem_req; StallM=0.
- LB with addr 0x103 and ack on the first cycle; rdata=0x80FF_0000 → ReadDataW=0xFFFF_FF80; dmem_addr=0x100; StallM never asserted.
- LHU with addr 0x102, ack after 3 cycles; rdata=0xBEEF_1234:
  - StallM=1 for 3 cycles, with bubbles in W.
  - Then ReadDataW=0x0000_BEEF.
  - dmem_addr stable throughout.
- SB with addr 0x201, WriteDataM=0xAB → dmem_be=0010, dmem_wdata=0xABAB_ABAB, dmem_we=1; RegWriteW=0.
- LW with addr 0x302 → no dmem_req; next cycle MisalignW=1, RegWriteW=0.
- rst_n low during WAIT → dmem_req=0 asynchronously, all W outputs 0, FSM IDLE. With DMEM_TIMEOUT_EN and TIMEOUT=16, no ack for 16 cycles → BusErrW=1 and StallM released.
